// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared opcodes, pc_src and forwarding encodings, the
//               scoreboard slot record and the forwarding-select helper for
//               the 5-stage 16-bit pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_W = 4;

    // Opcodes, instruction bits [15:12]
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LI   = 4'hA;
    localparam logic [3:0] OP_LHI  = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_EXEC = 4'hF;

    // PC mux select
    localparam logic [1:0] PC_SEQ      = 2'b00;
    localparam logic [1:0] PC_REDIR    = 2'b01;
    localparam logic [1:0] PC_EXEC_RET = 2'b10;

    // Operand forward select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // One in-flight instruction; dest is 0 when it writes no register
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
        logic [3:0]       op;
    } sb_slot_t;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_EXEC_FETCH = 1'b1
    } hz_state_t;

    // Youngest producer wins; R0 is hard-wired zero and never forwarded
    function automatic logic [1:0] fwd_pick(input logic used,
                                            input logic [REG_W-1:0] src,
                                            input sb_slot_t ex,
                                            input sb_slot_t mem);
        if (!used || src == '0)
            return FWD_RF;
        if (ex.valid && ex.dest == src)
            return FWD_EX;
        if (mem.valid && mem.dest == src)
            return FWD_MEM;
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_deps.sv
`default_nettype none
// ============================================================================
// Module      : instr_deps
// Description : Combinational decode of an instruction word into its register
//               sources, destination and load/control-flow class.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_deps
    import pipe_pkg::*;
#(
    parameter int ISIZE    = 16,
    parameter int RSIZE    = 4,
    parameter int LINK_REG = 15
) (
    input  logic [ISIZE-1:0] instr,
    output logic             use_rs,
    output logic             use_rt,
    output logic             use_rd,
    output logic [RSIZE-1:0] dest,
    output logic             is_load,
    output logic             is_ctrl,
    output logic [3:0]       op
);

    // Source/destination classification by opcode
    always_comb begin
        op      = instr[15:12];
        use_rs  = (op <= OP_SW);
        use_rt  = (op <= OP_OR);
        use_rd  = (op == OP_SW) || (op == OP_JR) || (op == OP_EXEC);
        is_load = (op == OP_LW);
        is_ctrl = (op >= OP_BR);
        dest    = '0;
        if (op <= OP_LW || op == OP_LI || op == OP_LHI)
            dest = instr[8 +: RSIZE];
        else if (op == OP_JAL)
            dest = RSIZE'(LINK_REG);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard sequencer for the IF/ID/EX/MEM/WB pipeline: EX/MEM
//               scoreboard, operand forwarding, load-use stall, redirect
//               flush, EXEC single-instruction detour and data-memory freeze.
//               Optional macro HAZ_PERF_CNT_EN adds saturating stall, flush
//               and freeze event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int ISIZE    = 16,
    parameter int RSIZE    = 4,
    parameter int LINK_REG = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ISIZE-1:0] id_instr,
    input  logic             id_valid,
    input  logic             ex_br_taken,
    input  logic [ISIZE-1:0] ex_pc_plus1,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic [1:0]       pc_src,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic [1:0]       fwd_rd,
    output logic [ISIZE-1:0] exec_ret_pc
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt,
    output logic [15:0]      freeze_cnt
`endif
);

    logic             use_rs, use_rt, use_rd, is_load, is_ctrl;
    logic [RSIZE-1:0] id_dest, rs, rt, rd;
    logic [3:0]       id_op;
    sb_slot_t         ex_slot, mem_slot, id_slot;
    hz_state_t        state, state_nxt;
    logic             exec_tgt;
    logic             freeze, redirect, load_use, exec_bub, exec_take;

    instr_deps #(
        .ISIZE    (ISIZE),
        .RSIZE    (RSIZE),
        .LINK_REG (LINK_REG)
    ) u_id_deps (
        .instr   (id_instr),
        .use_rs  (use_rs),
        .use_rt  (use_rt),
        .use_rd  (use_rd),
        .dest    (id_dest),
        .is_load (is_load),
        .is_ctrl (is_ctrl),
        .op      (id_op)
    );

    assign rd = id_instr[8 +: RSIZE];
    assign rs = id_instr[4 +: RSIZE];
    assign rt = id_instr[0 +: RSIZE];

    assign fwd_rs = fwd_pick(use_rs, rs, ex_slot, mem_slot);
    assign fwd_rt = fwd_pick(use_rt, rt, ex_slot, mem_slot);
    assign fwd_rd = fwd_pick(use_rd, rd, ex_slot, mem_slot);

    // Hazard detection from the scoreboard and the ID instruction
    always_comb begin
        freeze   = mem_slot.valid && (mem_slot.is_load || mem_slot.op == OP_SW)
                   && !dmem_ready;
        redirect = ex_slot.valid &&
                   ((ex_slot.op == OP_BR && ex_br_taken) || ex_slot.op == OP_JAL ||
                    ex_slot.op == OP_JR || ex_slot.op == OP_EXEC);
        load_use = ex_slot.valid && ex_slot.is_load && ex_slot.dest != '0 && id_valid &&
                   ((use_rs && rs == ex_slot.dest) || (use_rt && rt == ex_slot.dest) ||
                    (use_rd && rd == ex_slot.dest));
        // An EXEC landing as the target of an EXEC is squashed: no nested detour
        exec_bub  = exec_tgt && id_valid && is_ctrl && id_op == OP_EXEC;
        exec_take = redirect && state == ST_RUN && ex_slot.op == OP_EXEC;
    end

    // Next-state and pipeline control outputs, freeze first, then redirect
    always_comb begin
        state_nxt   = state;
        pc_hold     = 1'b0;
        pc_src      = PC_SEQ;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (freeze) begin
            pipe_freeze = 1'b1;
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            if (state == ST_EXEC_FETCH)
                pc_src = PC_EXEC_RET;
        end else begin
            if (state == ST_EXEC_FETCH) begin
                pc_src    = PC_EXEC_RET;
                state_nxt = ST_RUN;
            end
            if (redirect) begin
                pc_src      = PC_REDIR;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (exec_take)
                    state_nxt = ST_EXEC_FETCH;
            end else if (load_use) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end else if (exec_bub) begin
                idex_bubble = 1'b1;
            end
        end
    end

    // ID-stage record as it would enter EX this cycle
    always_comb begin
        id_slot         = '0;
        id_slot.valid   = id_valid && !idex_bubble;
        id_slot.dest    = id_dest;
        id_slot.is_load = is_load;
        id_slot.op      = id_op;
        if (!id_slot.valid)
            id_slot = '0;
    end

    // FSM, scoreboard advance and EXEC return capture; all hold on freeze
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            ex_slot     <= '0;
            mem_slot    <= '0;
            exec_tgt    <= 1'b0;
            exec_ret_pc <= '0;
        end else if (!pipe_freeze) begin
            state    <= state_nxt;
            ex_slot  <= id_slot;
            mem_slot <= ex_slot;
            exec_tgt <= (state == ST_EXEC_FETCH);
            if (exec_take)
                exec_ret_pc <= ex_pc_plus1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = load_use && !freeze && !redirect;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall_evt && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (redirect && !freeze && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
            if (freeze && freeze_cnt != 16'hFFFF)
                freeze_cnt <= freeze_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencer for the 5-stage 16-bit pipeline (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers in an internal EX/MEM scoreboard.
- Drives operand-forward selects, load-use stalls, control-flow flushes, the EXEC single-instruction detour and whole-pipe freeze on data-memory wait.
- Sits beside the decode-stage control decoder. Its outputs gate the pipeline registers and the PC mux.

Parameters:
ISIZE, 16, instruction/PC width
RSIZE, 4, register address width (R0 reads zero, never a hazard source)
LINK_REG, 15, JAL destination register

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
id_instr  input  ISIZE  instruction in ID; [15:12] op, [11:8] Rd, [7:4] Rs, [3:0] Rt
id_valid  input  1  ID holds a real instruction
ex_br_taken  input  1  branch condition true for B currently in EX
ex_pc_plus1  input  ISIZE  PC+1 of instruction in EX
dmem_ready  input  1  data memory done this cycle
pc_hold  output  1  PC keeps value
pc_src  output  2  00 sequential, 01 EX redirect target, 10 exec_ret_pc
ifid_hold  output  1  IF/ID keeps value
ifid_flush  output  1  IF/ID loads NOP
idex_bubble  output  1  ID/EX loads NOP
pipe_freeze  output  1  EX/MEM and MEM/WB hold
fwd_rs, fwd_rt, fwd_rd  output  2 each  00 regfile, 01 EX result, 10 MEM result
exec_ret_pc  output  ISIZE  return PC after EXEC target

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0, exec_ret_pc=0
  - scoreboard slots invalid
  - FSM=RUN
- Decode rules:
  - Rs is a source for ops 0-9.
  - Rt is a source for ops 0-3.
  - Rd is a source for SW(9), JR(E) and EXEC(F).
  - Destination: Rd for ops 0-8, A, B; LINK_REG for D; none otherwise.
  - Destination R0 is recorded as no destination.
- Scoreboard:
  - EX slot = {valid, dest, is_load, op} captured from ID each unfrozen cycle.
  - Captured as invalid when idex_bubble=1 or id_valid=0.
  - MEM slot <- EX slot.
  - Both hold while pipe_freeze=1.
- Forwarding (combinational):
  - For each used source: EX match -> 01, else MEM match -> 10, else 00.
  - EX has priority; address 0 is always 00.
- Load-use:
  - Condition: EX slot is LW and its dest matches a used ID source.
  - Response: pc_hold=ifid_hold=idex_bubble=1 for exactly one cycle.
  - Next cycle the match is seen in MEM and forwards as 10.
- Freeze: MEM slot is LW/SW and dmem_ready=0.
  - pipe_freeze=pc_hold=ifid_hold=1, no bubble, no flush.
  - FSM and scoreboard hold.
  - Freeze has highest priority.
- Redirect: EX slot is B with ex_br_taken, JAL, JR, or EXEC.
  - pc_src=01, ifid_flush=1, idex_bubble=1 for one cycle.
  - Overrides any load-use in the same cycle.
  - B not taken: no action (predict not-taken).
- FSM states RUN, EXEC_FETCH:
  - RUN -> EXEC_FETCH on EXEC redirect; exec_ret_pc <= ex_pc_plus1.
  - EXEC_FETCH (one cycle): pc_src=10, fetch proceeds, FSM -> RUN.
  - The target instruction then executes in ID normally.
  - If the EXEC target is itself EXEC, it is bubbled in ID (idex_bubble=1) and no second detour is taken.
  - Freeze during EXEC_FETCH holds the state and pc_src.
- Reset mid-operation: immediate return to reset values. In-flight EXEC return is lost.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - adds outputs stall_cnt, flush_cnt, freeze_cnt (16 bits each, saturating, reset 0)
  - counters increment on load-use stall, redirect and freeze cycles respectively
- When undefined: the ports and logic are absent.

Decomposition:
- Shared package `pipe_pkg`:
  - opcode constants OP_ADD..OP_EXEC
  - pc_src encodings
  - fwd encodings
  - scoreboard slot struct {valid, dest, is_load, op}
- Sub-module `instr_deps`: combinational decode of id_instr into use_rs/use_rt/use_rd/dest/is_load/is_ctrl. It is reused for both ID and scoreboard capture.

Test Plan:
- ADD R1,R2,R3 then SUB R4,R1,R1 -> fwd_rs=fwd_rt=01 in SUB's ID cycle; next independent instr 00.
- LW R5,0(R2) then ADD R6,R5,R0 -> one cycle pc_hold=ifid_hold=idex_bubble=1, then fwd_rs=10.
- B taken with ex_br_taken=1 at EX -> pc_src=01, ifid_flush=idex_bubble=1 for one cycle; B not taken -> no flush.
- EXEC R7 with ex_pc_plus1=0x0024 -> redirect cycle, then pc_src=10, exec_ret_pc=0x0024, FSM back to RUN.
- SW in MEM with dmem_ready=0 for 3 cycles while a LW-use pair sits in EX/ID -> pipe_freeze=1 for 3 cycles, then one load-use stall.
- rst_n pulsed low during EXEC_FETCH -> all outputs 0 asynchronously; after release, pc_src=00.
